// File: rtl/rr_fair_arbiter.sv
// Round-robin arbiter with a bounded hold time per owner, registered one-hot grants
// and per-requester wait counters that raise a sticky starvation flag.
module rr_fair_arbiter #(
  parameter int N          = 2,
  parameter int MAX_HOLD   = 4,
  parameter int WAIT_LIMIT = 5,
  localparam int IW        = (N > 1) ? $clog2(N) : 1,
  localparam int HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1,
  localparam int WW        = $clog2(WAIT_LIMIT + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id,
  output logic          starve
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam logic [WW-1:0] WAIT_MAX  = '1;
  localparam logic [WW-1:0] WAIT_TRIP = WW'(WAIT_LIMIT + 1);

  logic [0:0]    state, nxt_state;
  logic [IW-1:0] ptr, nxt_ptr;
  logic [HW-1:0] hold_cnt, nxt_hold;
  logic [N-1:0]  nxt_grant;
  logic [IW-1:0] nxt_id;
  logic [N-1:0]  others;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          load;

  logic [WW-1:0] wait_cnt     [N];
  logic [WW-1:0] nxt_wait_cnt [N];
  logic          starve_hit;

  // First requester in mask at or after start, wrapping modulo N.
  function automatic logic [IW:0] pick(input logic [N-1:0] mask, input logic [IW-1:0] start);
    logic [IW:0] r;
    int          idx;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % N;
      if (mask[idx]) r = {1'b1, IW'(idx)};
    end
    return r;
  endfunction

  // grant is zero in IDLE, so this is "all requests" there and "all but the owner" in OWN.
  assign others = req & ~grant;
  assign {pick_found, pick_idx} = pick(others, ptr);

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nxt_state = state;
    nxt_grant = grant;
    nxt_id    = grant_id;
    nxt_hold  = hold_cnt;
    nxt_ptr   = ptr;
    load      = 1'b0;
    case (state)
      IDLE: load = pick_found;
      OWN: begin
        if (!req[grant_id]) begin
          if (pick_found) begin
            load = 1'b1;
          end else begin
            nxt_state = IDLE;
            nxt_grant = '0;
            nxt_id    = '0;
            nxt_hold  = '0;
          end
        end else if (hold_cnt == HW'(MAX_HOLD) && pick_found) begin
          load = 1'b1;
        end else if (hold_cnt != HW'(MAX_HOLD)) begin
          nxt_hold = hold_cnt + HW'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
    if (load) begin
      nxt_state = OWN;
      nxt_grant = N'(1) << pick_idx;
      nxt_id    = pick_idx;
      nxt_hold  = HW'(1);
      nxt_ptr   = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
    end
  end

  always_comb begin
    starve_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      nxt_wait_cnt[i] = '0;
      if (req[i] && !grant[i])
        nxt_wait_cnt[i] = (wait_cnt[i] == WAIT_MAX) ? WAIT_MAX : wait_cnt[i] + WW'(1);
      if (nxt_wait_cnt[i] >= WAIT_TRIP) starve_hit = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the wait-counter
  // array is small and must start at zero, so it is reset along with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      starve      <= 1'b0;
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      state       <= nxt_state;
      ptr         <= nxt_ptr;
      hold_cnt    <= nxt_hold;
      grant       <= nxt_grant;
      grant_valid <= |nxt_grant;
      grant_id    <= nxt_id;
      starve      <= starve | starve_hit;
      for (int i = 0; i < N; i++) wait_cnt[i] <= nxt_wait_cnt[i];
    end
  end

endmodule

// File: tb/tb_rr_fair_arbiter.sv
// Directed bench for rr_fair_arbiter: a default instance for grant sequencing and
// fairness, and a WAIT_LIMIT=2 instance for the starvation flag and async reset.
module tb_rr_fair_arbiter;

  logic       clk;
  logic       rst_a, rst_b;
  logic [1:0] req_a, req_b;
  logic [1:0] grant_a, grant_b;
  logic       valid_a, valid_b;
  logic [0:0] id_a, id_b;
  logic       starve_a, starve_b;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [1:0] g;
    logic       s;
    string      tag;
  } exp_t;

  exp_t sb[$];

  rr_fair_arbiter dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .grant(grant_a),
    .grant_valid(valid_a), .grant_id(id_a), .starve(starve_a)
  );

  rr_fair_arbiter #(.N(2), .MAX_HOLD(4), .WAIT_LIMIT(2)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .grant(grant_b),
    .grant_valid(valid_b), .grant_id(id_b), .starve(starve_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic compare_outputs(input bit b, input logic [1:0] g, input logic s, input string tag);
    logic [1:0] og;
    logic       ov, os;
    logic [0:0] oi;
    og = b ? grant_b  : grant_a;
    ov = b ? valid_b  : valid_a;
    oi = b ? id_b     : id_a;
    os = b ? starve_b : starve_a;
    check({tag, ".grant"},  8'(og), 8'(g));
    check({tag, ".valid"},  8'(ov), 8'(|g));
    check({tag, ".id"},     8'(oi), 8'(g[1]));
    check({tag, ".starve"}, 8'(os), 8'(s));
  endtask

  // Drive req, queue the grant expected after the next edge, then pop and compare.
  task automatic cyc(input bit b, input logic [1:0] r, input logic [1:0] g,
                     input logic s, input string tag);
    exp_t e;
    if (b) req_b = r;
    else   req_a = r;
    sb.push_back('{g: g, s: s, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare_outputs(b, e.g, e.s, e.tag);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    req_a = 2'b11;
    req_b = 2'b00;

    // T1: requests held during reset produce nothing.
    repeat (3) begin
      @(posedge clk);
      #1;
      compare_outputs(1'b0, 2'b00, 1'b0, "t1_in_reset");
    end
    rst_a = 1'b0;

    // T1/T3: contention from reset release, 4-cycle slices alternating from requester 0.
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b11, 2'b01, 1'b0, "t3_slice0");
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b11, 2'b10, 1'b0, "t3_slice1");
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b11, 2'b01, 1'b0, "t3_slice2");
    cyc(1'b0, 2'b00, 2'b00, 1'b0, "t3_release");

    // T2: single request is granted next edge and held; drop releases next edge.
    for (int i = 0; i < 10; i++) cyc(1'b0, 2'b01, 2'b01, 1'b0, "t2_single");
    cyc(1'b0, 2'b00, 2'b00, 1'b0, "t2_drop");

    // T5: owner 0 drops after 2 cycles while 1 waits -> direct handoff, no idle gap.
    cyc(1'b0, 2'b01, 2'b01, 1'b0, "t5_own0");
    cyc(1'b0, 2'b11, 2'b01, 1'b0, "t5_own0_contend");
    cyc(1'b0, 2'b10, 2'b10, 1'b0, "t5_handoff");
    cyc(1'b0, 2'b10, 2'b10, 1'b0, "t5_own1");
    cyc(1'b0, 2'b00, 2'b00, 1'b0, "t5_idle");

    // T4: grant 10 just started, req[0] rises and must be served within 5 edges.
    cyc(1'b0, 2'b10, 2'b10, 1'b0, "t4_start1");
    cyc(1'b0, 2'b11, 2'b10, 1'b0, "t4_wait_e1");
    cyc(1'b0, 2'b11, 2'b10, 1'b0, "t4_wait_e2");
    cyc(1'b0, 2'b11, 2'b10, 1'b0, "t4_wait_e3");
    cyc(1'b0, 2'b11, 2'b01, 1'b0, "t4_served_e4");
    cyc(1'b0, 2'b00, 2'b00, 1'b0, "t4_idle");

    // T6: tight WAIT_LIMIT makes requester 1 starve while 0 holds its slice.
    rst_b = 1'b0;
    cyc(1'b1, 2'b11, 2'b01, 1'b0, "t6_e1");
    cyc(1'b1, 2'b11, 2'b01, 1'b0, "t6_e2");
    cyc(1'b1, 2'b11, 2'b01, 1'b1, "t6_e3_starve");
    cyc(1'b1, 2'b11, 2'b01, 1'b1, "t6_e4_sticky");

    // Async reset mid-cycle while owner 0 holds (ptr=1): outputs clear before any edge.
    #3;
    rst_b = 1'b1;
    #1;
    compare_outputs(1'b1, 2'b00, 1'b0, "t6_async_rst");
    @(posedge clk);
    #1;
    compare_outputs(1'b1, 2'b00, 1'b0, "t6_rst_held");
    rst_b = 1'b0;
    // ptr back at 0, so requester 0 wins first rather than 1.
    cyc(1'b1, 2'b11, 2'b01, 1'b0, "t6_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
